// File: rtl/keypad_entry_if.sv
// rtl/keypad_entry_if.sv - committed-setpoint valid/ack handshake between keypad_entry and the countdown core
//
// Signals:
//   value        16  committed BCD setpoint {m10,m1,s10,s1}, stable while value_valid=1
//   value_valid   1  committed setpoint pending
//   value_ack     1  consumer accepts value; clears value_valid at the sampling edge
// Modports:
//   master  keypad_entry side (drives value/value_valid)
//   slave   countdown core side (drives value_ack)
interface keypad_entry_if;
  logic [15:0] value;
  logic        value_valid;
  logic        value_ack;

  modport master (output value, output value_valid, input value_ack);
  modport slave  (input value, input value_valid, output value_ack);
endinterface

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - debounces scanner key events and assembles a 4-digit BCD MM:SS setpoint
//
// Parameters:
//   DEBOUNCE_CYCLES  stable scan clocks required for press and for release (1..15)
// Ports:
//   scan_clk     in   1  scan clock shared with the keypad driver
//   rst          in   1  synchronous active-high reset
//   keydown      in   1  key-held flag from the scanner
//   key          in   4  key code (row*4+col), stable while keydown=1
//   entry        out 16  live BCD digits {d3,d2,d1,d0}, d0 most recent
//   digit_count  out  3  digits entered, 0..4
//   err          out  1  one-cycle pulse on a rejected key action
//   val_if       master  value/value_valid/value_ack handshake
// Build option:
//   KEYPAD_ENTRY_RANGE_CHECK_EN  reject COMMIT when the seconds-tens digit exceeds 5
module keypad_entry #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic           scan_clk,
  input  logic           rst,
  input  logic           keydown,
  input  logic [3:0]     key,
  output logic [15:0]    entry,
  output logic [2:0]     digit_count,
  output logic           err,
  keypad_entry_if.master val_if
);

  localparam logic [3:0] DC = 4'(DEBOUNCE_CYCLES);

  localparam logic [3:0] KEY_CLEAR  = 4'd10;
  localparam logic [3:0] KEY_BACK   = 4'd11;
  localparam logic [3:0] KEY_COMMIT = 4'd12;

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  cur_key_q, cur_key_d;
  logic [15:0] entry_q, entry_d;
  logic [2:0]  count_q, count_d;
  logic [15:0] value_q, value_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  // One-cycle strobe from the FSM: the press has been stable long enough.
  logic        accept;
  logic [3:0]  acc_key;

  always_ff @(posedge scan_clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      cur_key_q <= 4'd0;
      entry_q   <= 16'h0;
      count_q   <= 3'd0;
      value_q   <= 16'h0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_key_q <= cur_key_d;
      entry_q   <= entry_d;
      count_q   <= count_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  // Debounce FSM. cnt counts stable presses in DEBOUNCE and stable
  // releases in HELD; the edge that samples the DC-th one acts.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_key_d = cur_key_q;
    accept    = 1'b0;
    acc_key   = cur_key_q;
    case (state_q)
      S_IDLE: begin
        if (keydown) begin
          cur_key_d = key;
          acc_key   = key;
          if (DC == 4'd1) begin
            accept  = 1'b1;
            state_d = S_HELD;
            cnt_d   = 4'd0;
          end else begin
            state_d = S_DEBOUNCE;
            cnt_d   = 4'd1;
          end
        end
      end
      S_DEBOUNCE: begin
        if (keydown && (key == cur_key_q)) begin
          if (cnt_q + 4'd1 == DC) begin
            accept  = 1'b1;
            state_d = S_HELD;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      end
      S_HELD: begin
        if (keydown) begin
          cnt_d = 4'd0;
        end else if (cnt_q + 4'd1 == DC) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Key actions and handshake. COMMIT looks at valid_q (pre-ack), so a
  // commit landing on the ack edge is still seen as pending and dropped.
  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    value_d = value_q;
    valid_d = valid_q & ~val_if.value_ack;
    err_d   = 1'b0;
    if (accept) begin
      if (acc_key <= 4'd9) begin
        if (count_q < 3'd4) begin
          entry_d = {entry_q[11:0], acc_key};
          count_d = count_q + 3'd1;
        end else begin
          err_d = 1'b1;
        end
      end else if (acc_key == KEY_CLEAR) begin
        entry_d = 16'h0;
        count_d = 3'd0;
      end else if (acc_key == KEY_BACK) begin
        if (count_q != 3'd0) begin
          entry_d = {4'h0, entry_q[15:4]};
          count_d = count_q - 3'd1;
        end
      end else if (acc_key == KEY_COMMIT) begin
        if (count_q == 3'd0) begin
          err_d = 1'b1;
        end else if (valid_q) begin
          err_d = 1'b0;
`ifdef KEYPAD_ENTRY_RANGE_CHECK_EN
        end else if (entry_q[7:4] > 4'd5) begin
          err_d = 1'b1;
`endif
        end else begin
          value_d = entry_q;
          valid_d = 1'b1;
          entry_d = 16'h0;
          count_d = 3'd0;
        end
      end
    end
  end

  assign entry              = entry_q;
  assign digit_count        = count_q;
  assign err                = err_q;
  assign val_if.value       = value_q;
  assign val_if.value_valid = valid_q;

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - self-checking bench for keypad_entry
module tb_keypad_entry;

  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        keydown;
  logic [3:0]  key;
  logic [15:0] entry;
  logic [2:0]  digit_count;
  logic        err;

  keypad_entry_if vif();

  keypad_entry #(.DEBOUNCE_CYCLES(DC)) dut (
    .scan_clk    (clk),
    .rst         (rst),
    .keydown     (keydown),
    .key         (key),
    .entry       (entry),
    .digit_count (digit_count),
    .err         (err),
    .val_if      (vif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  k;
    logic [15:0] e_entry;
    logic [2:0]  e_cnt;
    logic [15:0] e_val;
    logic        e_valid;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  // Reference model: digits kept as a list, newest last.
  int          md[$];
  logic [15:0] m_val;
  logic        m_valid;
  logic        m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e, input logic [2:0] c,
                         input logic [15:0] v, input logic vv, input logic er);
    chk({tag, "_entry"}, 32'(entry), 32'(e));
    chk({tag, "_count"}, 32'(digit_count), 32'(c));
    chk({tag, "_value"}, 32'(vif.value), 32'(v));
    chk({tag, "_valid"}, 32'(vif.value_valid), 32'(vv));
    chk({tag, "_err"}, 32'(err), 32'(er));
  endtask

  task automatic do_press(input logic [3:0] k);
    keydown = 1'b1;
    key = k;
    repeat (10) tick();
    keydown = 1'b0;
    repeat (10) tick();
  endtask

  function automatic logic [15:0] m_entry();
    int e = 0;
    foreach (md[i]) e = e * 16 + md[i];
    return 16'(e);
  endfunction

  function automatic void model_step(input bit act, input logic [3:0] k, input logic ack);
    logic        old_valid;
    logic [15:0] ent;
    old_valid = m_valid;
    m_err = 1'b0;
    if (ack && m_valid) m_valid = 1'b0;
    if (act) begin
      if (k <= 4'd9) begin
        if (md.size() < 4) md.push_back(int'(k));
        else m_err = 1'b1;
      end else if (k == 4'd10) begin
        md.delete();
      end else if (k == 4'd11) begin
        if (md.size() > 0) void'(md.pop_back());
      end else if (k == 4'd12) begin
        ent = m_entry();
        if (md.size() == 0) m_err = 1'b1;
        else if (!old_valid) begin
`ifdef KEYPAD_ENTRY_RANGE_CHECK_EN
          if (((ent >> 4) & 16'hf) > 16'd5) m_err = 1'b1;
          else begin
            m_val = ent; m_valid = 1'b1; md.delete();
          end
`else
          m_val = ent; m_valid = 1'b1; md.delete();
`endif
        end
      end
    end
  endfunction

  task automatic rtick(input bit act, input logic [3:0] k);
    vif.value_ack = ($urandom_range(0, 5) == 0);
    model_step(act, k, vif.value_ack);
    tick();
    chk_all("rnd", m_entry(), 3'(md.size()), m_val, m_valid, m_err);
  endtask

  initial begin
    logic [2:0] prev_cnt;
    rst = 1'b1;
    keydown = 1'b0;
    key = 4'd0;
    vif.value_ack = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk_all("reset", 16'h0, 3'd0, 16'h0, 1'b0, 1'b0);

    // key, entry, count, value, valid, err at the accepting edge
    tbl.push_back('{4'd1,  16'h0001, 3'd1, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{4'd2,  16'h0012, 3'd2, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{4'd3,  16'h0123, 3'd3, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{4'd4,  16'h1234, 3'd4, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{4'd5,  16'h1234, 3'd4, 16'h0000, 1'b0, 1'b1});
    tbl.push_back('{4'd11, 16'h0123, 3'd3, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{4'd10, 16'h0000, 3'd0, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{4'd11, 16'h0000, 3'd0, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{4'd12, 16'h0000, 3'd0, 16'h0000, 1'b0, 1'b1});
    tbl.push_back('{4'd1,  16'h0001, 3'd1, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{4'd2,  16'h0012, 3'd2, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{4'd3,  16'h0123, 3'd3, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{4'd4,  16'h1234, 3'd4, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{4'd12, 16'h0000, 3'd0, 16'h1234, 1'b1, 1'b0});
    tbl.push_back('{4'd5,  16'h0005, 3'd1, 16'h1234, 1'b1, 1'b0});
    tbl.push_back('{4'd12, 16'h0005, 3'd1, 16'h1234, 1'b1, 1'b0});
    tbl.push_back('{4'd13, 16'h0005, 3'd1, 16'h1234, 1'b1, 1'b0});
    tbl.push_back('{4'd10, 16'h0000, 3'd0, 16'h1234, 1'b1, 1'b0});

    prev_cnt = 3'd0;
    for (int i = 0; i < tbl.size(); i++) begin
      keydown = 1'b1;
      key = tbl[i].k;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (c == DC - 2) chk("tbl_pre_count", 32'(digit_count), 32'(prev_cnt));
        if (c == DC - 1) chk_all("tbl", tbl[i].e_entry, tbl[i].e_cnt, tbl[i].e_val,
                                 tbl[i].e_valid, tbl[i].e_err);
        if (c == DC) chk("tbl_err_pulse", 32'(err), 32'd0);
      end
      keydown = 1'b0;
      repeat (10) tick();
      prev_cnt = tbl[i].e_cnt;
    end

    // Ack clears value_valid at the edge that samples it.
    vif.value_ack = 1'b1;
    tick();
    vif.value_ack = 1'b0;
    chk("ack_valid", 32'(vif.value_valid), 32'd0);
    chk("ack_value", 32'(vif.value), 32'h1234);

    // Bounce: 3 high, 1 low, then a clean hold of key 7.
    keydown = 1'b1; key = 4'd7;
    repeat (3) tick();
    keydown = 1'b0;
    tick();
    keydown = 1'b1;
    repeat (3) tick();
    chk("bounce_early", 32'(digit_count), 32'd0);
    tick();
    chk("bounce_entry", 32'(entry), 32'h0007);
    repeat (6) tick();
    keydown = 1'b0;
    repeat (10) tick();
    chk("bounce_once", 32'(entry), 32'h0007);
    chk("bounce_count", 32'(digit_count), 32'd1);

    // Seconds-tens range check.
    do_press(4'd10);
    do_press(4'd0); do_press(4'd1); do_press(4'd7); do_press(4'd0);
    keydown = 1'b1; key = 4'd12;
    repeat (DC) tick();
`ifdef KEYPAD_ENTRY_RANGE_CHECK_EN
    chk_all("range170", 16'h0170, 3'd4, 16'h1234, 1'b0, 1'b1);
`else
    chk_all("range170", 16'h0000, 3'd0, 16'h0170, 1'b1, 1'b0);
`endif
    keydown = 1'b0;
    repeat (10) tick();
    vif.value_ack = 1'b1; tick(); vif.value_ack = 1'b0;
    do_press(4'd10);
    do_press(4'd0); do_press(4'd1); do_press(4'd5); do_press(4'd9);
    do_press(4'd12);
    chk_all("range159", 16'h0000, 3'd0, 16'h0159, 1'b1, 1'b0);

    // Reset mid-debounce with a pending value; held key re-debounces.
    do_press(4'd3);
    chk("pre_rst_entry", 32'(entry), 32'h0003);
    keydown = 1'b1; key = 4'd8;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("rst_mid", 16'h0, 3'd0, 16'h0, 1'b0, 1'b0);
    repeat (DC - 1) tick();
    chk("rst_redeb_early", 32'(digit_count), 32'd0);
    tick();
    chk("rst_redeb_entry", 32'(entry), 32'h0008);
    repeat (5) tick();
    keydown = 1'b0;
    repeat (10) tick();

    // COMMIT accepted on the same edge as an ack is dropped.
    do_press(4'd12);
    chk_all("commit8", 16'h0, 3'd0, 16'h0008, 1'b1, 1'b0);
    do_press(4'd2);
    keydown = 1'b1; key = 4'd12;
    for (int c = 0; c < 10; c++) begin
      vif.value_ack = (c == DC - 1);
      tick();
      if (c == DC - 1) chk_all("ack_commit", 16'h0002, 3'd1, 16'h0008, 1'b0, 1'b0);
    end
    vif.value_ack = 1'b0;
    keydown = 1'b0;
    repeat (10) tick();

    // Randomized presses against the model.
    rst = 1'b1; tick(); rst = 1'b0;
    md.delete(); m_val = 16'h0; m_valid = 1'b0; m_err = 1'b0;
    for (int p = 0; p < 300; p++) begin
      logic [3:0] rk;
      int hold;
      int gap;
      if ($urandom_range(0, 3) == 0) begin
        keydown = 1'b1; key = 4'($urandom_range(0, 15));
        for (int g = 0; g < int'($urandom_range(1, DC - 1)); g++) rtick(1'b0, key);
        keydown = 1'b0;
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) rtick(1'b0, key);
      end
      rk = 4'($urandom_range(0, 15));
      hold = int'($urandom_range(DC, DC + 5));
      gap = int'($urandom_range(DC, DC + 4));
      keydown = 1'b1; key = rk;
      for (int c = 0; c < hold; c++) rtick(c == DC - 1, rk);
      keydown = 1'b0;
      for (int c = 0; c < gap; c++) rtick(1'b0, rk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
